pattern_player: RTL and testbench



---
 rtl/pattern_player.sv | 165 ++++++++++++++++
 tb/tb_pattern_player.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_player.sv
// Stores the game's symbol sequence and plays it back on one-hot LEDs with fixed on/gap timing.
// Optional REVERSE_PLAY_EN adds a 'reverse' input for last-to-first playback.
module pattern_player #(
    parameter int unsigned MAX_LEN    = 32,
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned GAP_CYCLES = 12_500_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         append,
    input  logic [2:0]                   sym_in,
    input  logic                         start,
`ifdef REVERSE_PLAY_EN
    input  logic                         reverse,
`endif
    output logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic                         full,
    output logic                         busy,
    output logic [7:0]                   led,
    output logic                         done
);

    localparam int unsigned LenW     = $clog2(MAX_LEN + 1);
    localparam int unsigned IdxW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TimerMax = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    typedef enum logic [1:0] {StIdle, StOn, StGap, StFin} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [LenW-1:0]     len_q, len_d;
    logic                full_q, full_d;
    logic                rev_q, rev_d;
    logic                rev_in;
    logic                mem_we;
    logic [7:0]          led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IdxW-1:0]     last_idx;
    logic [2:0]          mem [MAX_LEN];

`ifdef REVERSE_PLAY_EN
    assign rev_in = reverse;
`else
    assign rev_in = 1'b0;
`endif

    assign last_idx = IdxW'(len_q - LenW'(1));

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            timer_q <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            rev_q   <= 1'b0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            len_q   <= len_d;
            full_q  <= full_d;
            rev_q   <= rev_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Symbol storage carries no reset; contents past len are never shown.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[len_q[IdxW-1:0]] <= sym_in;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q + 1'b1;
        len_d   = len_q;
        rev_d   = rev_q;
        mem_we  = 1'b0;
        if (clr) begin
            state_d = StIdle;
            len_d   = '0;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_d = '0;
                    if (append) begin
                        // append outranks start; a full store drops the symbol
                        if (!full_q) begin
                            mem_we = 1'b1;
                            len_d  = len_q + 1'b1;
                        end
                    end else if (start) begin
                        rev_d = rev_in;
                        if (len_q == '0) begin
                            state_d = StFin;
                        end else begin
                            state_d = StOn;
                            idx_d   = rev_in ? last_idx : '0;
                        end
                    end
                end
                StOn: begin
                    if (timer_q == TimerW'(ON_CYCLES - 1)) begin
                        state_d = StGap;
                        timer_d = '0;
                    end
                end
                StGap: begin
                    if (timer_q == TimerW'(GAP_CYCLES - 1)) begin
                        timer_d = '0;
                        if (rev_q ? (idx_q == '0) : (idx_q == last_idx)) begin
                            state_d = StFin;
                        end else begin
                            state_d = StOn;
                            idx_d   = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
                        end
                    end
                end
                StFin: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        full_d = (len_d == LenW'(MAX_LEN));
        led_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            StOn: begin
                led_d  = 8'(1) << mem[idx_d];
                busy_d = 1'b1;
            end
            StGap:   busy_d = 1'b1;
            StFin:   done_d = 1'b1;
            default: ;
        endcase
    end

    assign len  = len_q;
    assign full = full_q;
    assign busy = busy_q;
    assign led  = led_q;
    assign done = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Directed self-checking bench for pattern_player (ON=4, GAP=2, MAX_LEN=4).
module tb_pattern_player;

    localparam int unsigned MaxLen = 4;
    localparam int unsigned OnCyc  = 4;
    localparam int unsigned GapCyc = 2;

    logic       clk = 1'b0;
    logic       rst_n, clr, append, start;
    logic [2:0] sym_in;
    logic [2:0] len;
    logic       full, busy, done;
    logic [7:0] led;
`ifdef REVERSE_PLAY_EN
    logic       reverse = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pattern_player #(
        .MAX_LEN    (MaxLen),
        .ON_CYCLES  (OnCyc),
        .GAP_CYCLES (GapCyc)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .append (append),
        .sym_in (sym_in),
        .start  (start),
`ifdef REVERSE_PLAY_EN
        .reverse(reverse),
`endif
        .len    (len),
        .full   (full),
        .busy   (busy),
        .led    (led),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [2:0] s);
        append = 1'b1;
        sym_in = s;
        step();
        append = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Checks {busy,done,led} every cycle of a playback of n symbols.
    task automatic play(input logic [2:0] syms [4], input int n, input bit restart);
        int cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < int'(OnCyc); c++) begin
                chk("play_on", {22'd0, busy, done, led}, {22'd0, 2'b10, 8'(1) << syms[k]});
                start = restart && (cyc == 1);
                step();
                cyc++;
            end
            for (int c = 0; c < int'(GapCyc); c++) begin
                chk("play_gap", {22'd0, busy, done, led}, {22'd0, 2'b10, 8'h00});
                start = restart && (cyc == 1);
                step();
                cyc++;
            end
        end
        start = 1'b0;
        chk("play_done", {22'd0, busy, done, led}, {22'd0, 2'b01, 8'h00});
        step();
        chk("play_idle", {22'd0, busy, done, led}, 32'd0);
    endtask

    initial begin
        logic [2:0] s [4];
        rst_n  = 1'b0;
        clr    = 1'b0;
        append = 1'b0;
        start  = 1'b0;
        sym_in = 3'd0;
        step();
        step();
        chk("rst_len", 32'(len), 32'd0);
        chk("rst_outs", {28'd0, full, busy, done, |led}, 32'd0);
        rst_n = 1'b1;

        // single symbol
        push(3'd5);
        chk("len_one", 32'(len), 32'd1);
        s = '{3'd5, 3'd0, 3'd0, 3'd0};
        play(s, 1, 1'b0);
        chk("len_kept", 32'(len), 32'd1);

        // three symbols, played twice
        do_clr();
        chk("clr_len", 32'(len), 32'd0);
        push(3'd0);
        push(3'd7);
        push(3'd3);
        chk("len_three", 32'(len), 32'd3);
        s = '{3'd0, 3'd7, 3'd3, 3'd0};
        play(s, 3, 1'b0);
        play(s, 3, 1'b0);

        // fill to capacity, overflow ignored
        do_clr();
        push(3'd1);
        push(3'd2);
        push(3'd3);
        chk("not_full", {31'd0, full}, 32'd0);
        push(3'd4);
        chk("full_len", 32'(len), 32'd4);
        chk("full_flag", {31'd0, full}, 32'd1);
        push(3'd6);
        chk("ovf_len", 32'(len), 32'd4);
        s = '{3'd1, 3'd2, 3'd3, 3'd4};
        play(s, 4, 1'b0);

        // clr during the second ON of a three-symbol playback
        do_clr();
        push(3'd0);
        push(3'd7);
        push(3'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("second_on", {24'd0, led}, 32'h80);
        do_clr();
        chk("abort_outs", {22'd0, busy, done, led}, 32'd0);
        chk("abort_len", 32'(len), 32'd0);
        step();
        chk("abort_nodone", {31'd0, done}, 32'd0);

        // start with empty store
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty_done", {30'd0, busy, done}, 32'd1);
        step();
        chk("empty_after", {30'd0, busy, done}, 32'd0);

        // start together with append
        append = 1'b1;
        start  = 1'b1;
        sym_in = 3'd2;
        step();
        append = 1'b0;
        start  = 1'b0;
        chk("sa_len", 32'(len), 32'd1);
        chk("sa_idle", {22'd0, busy, done, led}, 32'd0);
        step();
        chk("sa_idle2", {22'd0, busy, done, led}, 32'd0);

        // start while busy is ignored
        s = '{3'd2, 3'd0, 3'd0, 3'd0};
        play(s, 1, 1'b1);

`ifdef REVERSE_PLAY_EN
        do_clr();
        push(3'd0);
        push(3'd7);
        push(3'd3);
        reverse = 1'b1;
        s = '{3'd3, 3'd7, 3'd0, 3'd0};
        play(s, 3, 1'b0);
        reverse = 1'b0;
        s = '{3'd0, 3'd7, 3'd3, 3'd0};
        play(s, 3, 1'b0);
`endif

        // reset mid-playback
        do_clr();
        push(3'd6);
        push(3'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_rst_led", {24'd0, led}, 32'h40);
        rst_n = 1'b0;
        step();
        chk("mid_rst_outs", {21'd0, full, busy, done, led}, 32'd0);
        chk("mid_rst_len", 32'(len), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst", {22'd0, busy, done, led}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
